// File: rtl/draw_score_pkg.sv
// rtl/draw_score_pkg.sv - shared VGA widths, pipeline bundle type and box helper
package draw_score_pkg;

    localparam int CNT_W   = 11;
    localparam int RGB_W   = 12;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int CODE_W  = 7;
    localparam int LINE_W  = 4;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
        logic [RGB_W-1:0] rgb;
    } vga_t;

    // True when lo <= v < lo+span; compared one bit wider so lo+span cannot wrap
    function automatic logic in_span(input logic [CNT_W-1:0] v,
                                     input int unsigned      lo,
                                     input int unsigned      span);
        logic [CNT_W:0] ext;
        ext = {1'b0, v};
        return (ext >= (CNT_W+1)'(lo)) && (ext < (CNT_W+1)'(lo + span));
    endfunction

endpackage

// File: rtl/draw_score_delay.sv
// rtl/draw_score_delay.sv - WIDTH x CLK_DEL shift register with async active-low reset
module draw_score_delay #(
    parameter int WIDTH   = 1,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [CLK_DEL];

    // Shift the word one stage per clock; reset empties every stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CLK_DEL; i++) stages[i] <= '0;
        end else begin
            stages[0] <= d;
            for (int i = 1; i < CLK_DEL; i++) stages[i] <= stages[i-1];
        end
    end

    assign q = stages[CLK_DEL-1];

endmodule

// File: rtl/draw_score.sv
// rtl/draw_score.sv - two-digit 8x16 score overlay on the VGA stream, 3 clk latency
module draw_score
    import draw_score_pkg::*;
#(
    parameter int unsigned      XPOS      = 700,
    parameter int unsigned      YPOS      = 20,
    parameter logic [RGB_W-1:0] TXT_COLOR = 12'hFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  hcount_in,
    input  logic [CNT_W-1:0]  vcount_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              hblnk_in,
    input  logic              vblnk_in,
    input  logic [RGB_W-1:0]  rgb_in,
    input  logic [CODE_W-1:0] msd_ascii,
    input  logic [CODE_W-1:0] lsd_ascii,
    output logic [CODE_W-1:0] char_code,
    output logic [LINE_W-1:0] char_line,
    input  logic [GLYPH_W-1:0] char_pixels,
    output logic [CNT_W-1:0]  hcount_out,
    output logic [CNT_W-1:0]  vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [RGB_W-1:0]  rgb_out
);

    logic              vblnk_prev;
    logic [CODE_W-1:0] msd_q;
    logic [CODE_W-1:0] lsd_q;

    logic              in_box;
    logic [3:0]        xoff;
    logic [LINE_W-1:0] yoff;

    logic [2:0]        s1_xbit;
    logic              s1_in_box;
    logic [2:0]        s2_xbit;
    logic              s2_in_box;
    logic [2:0]        bit_idx;

    vga_t              vga_now;
    vga_t              vga_d2;

    assign in_box = in_span(hcount_in, XPOS, 2 * GLYPH_W) && in_span(vcount_in, YPOS, GLYPH_H);
    assign xoff   = 4'(hcount_in - CNT_W'(XPOS));
    assign yoff   = LINE_W'(vcount_in - CNT_W'(YPOS));

    // Digits only change at the start of vertical blank so a frame never shows two scores
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vblnk_prev <= 1'b0;
            msd_q      <= '0;
            lsd_q      <= '0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblnk_in && !vblnk_prev) begin
                msd_q <= msd_ascii;
                lsd_q <= lsd_ascii;
            end
        end
    end

    // Stage 1 addresses the font ROM; stage 2 waits for its registered data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            char_code <= '0;
            char_line <= '0;
            s1_xbit   <= '0;
            s1_in_box <= 1'b0;
            s2_xbit   <= '0;
            s2_in_box <= 1'b0;
        end else begin
            if (in_box) begin
                char_code <= xoff[3] ? lsd_q : msd_q;
                char_line <= yoff;
            end
            s1_xbit   <= xoff[2:0];
            s1_in_box <= in_box;
            s2_xbit   <= s1_xbit;
            s2_in_box <= s1_in_box;
        end
    end

    assign vga_now = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in, vsync: vsync_in,
                       hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};

    draw_score_delay #(
        .WIDTH   ($bits(vga_t)),
        .CLK_DEL (2)
    ) u_timing_delay (
        .clk (clk),
        .rst (rst),
        .d   (vga_now),
        .q   (vga_d2)
    );

    // Glyph bit 7 is the leftmost pixel of the cell
    assign bit_idx = 3'(GLYPH_W - 1) - s2_xbit;

    // Stage 3 merges the glyph into the stream and registers every output together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= vga_d2.hcount;
            vcount_out <= vga_d2.vcount;
            hsync_out  <= vga_d2.hsync;
            vsync_out  <= vga_d2.vsync;
            hblnk_out  <= vga_d2.hblnk;
            vblnk_out  <= vga_d2.vblnk;
            rgb_out    <= (s2_in_box && char_pixels[bit_idx]) ? TXT_COLOR : vga_d2.rgb;
        end
    end

endmodule

// File: tb/tb_draw_score.sv
// tb/tb_draw_score.sv - scoreboard bench for the score overlay stage
module tb_draw_score;

    localparam int XP = 700;
    localparam int YP = 20;
    localparam logic [11:0] TXT = 12'hFFF;

    typedef struct {
        logic [10:0] hc;
        logic [10:0] vc;
        logic [3:0]  tim;
        logic [11:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [6:0]  msd_ascii, lsd_ascii;
    logic [6:0]  char_code;
    logic [3:0]  char_line;
    logic [7:0]  char_pixels;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    exp_t       sb_q[$];
    logic       rom_force_en;
    logic [7:0] rom_force;
    logic [6:0] g_msd, g_lsd;
    logic [6:0] m_msd, m_lsd, m_code;
    logic [3:0] m_line;
    logic       m_prev;
    logic [6:0] exp_code;
    logic [3:0] exp_line;

    always #5 clk = ~clk;

    draw_score dut (
        .clk        (clk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .msd_ascii  (msd_ascii),
        .lsd_ascii  (lsd_ascii),
        .char_code  (char_code),
        .char_line  (char_line),
        .char_pixels(char_pixels),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out)
    );

    function automatic logic [7:0] rom_fn(input logic [6:0] code, input logic [3:0] line);
        return rom_force_en ? rom_force : ({code[3:0], line} ^ 8'h5A);
    endfunction

    // Synchronous font ROM model
    always @(posedge clk) char_pixels <= rom_fn(char_code, char_line);

    // One pixel clock: check outputs due now, then apply new inputs and predict
    task automatic drive(input int hc, input int vc, input logic vb);
        exp_t       e;
        logic [7:0] row;
        logic       inb;
        int         dx, dy;
        @(negedge clk);
        if (sb_q.size() == 3) begin
            e = sb_q.pop_front();
            chk_cnt++;
            if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !==
                {e.hc, e.vc, e.tim}) begin
                $display("FAIL sb_timing got %h/%h/%b exp %h/%h/%b", hcount_out, vcount_out,
                         {hsync_out, vsync_out, hblnk_out, vblnk_out}, e.hc, e.vc, e.tim);
            end else pass_cnt++;
            chk_cnt++;
            if (rgb_out !== e.rgb)
                $display("FAIL sb_rgb at h=%0d v=%0d got %h exp %h", e.hc, e.vc, rgb_out, e.rgb);
            else pass_cnt++;
        end
        chk_cnt++;
        if ({char_code, char_line} !== {exp_code, exp_line})
            $display("FAIL rom_addr got %h/%0d exp %h/%0d", char_code, char_line, exp_code, exp_line);
        else pass_cnt++;
        hcount_in = 11'(hc);
        vcount_in = 11'(vc);
        vblnk_in  = vb;
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        hblnk_in  = 1'($urandom);
        rgb_in    = 12'($urandom);
        msd_ascii = g_msd;
        lsd_ascii = g_lsd;
        dx  = hc - XP;
        dy  = vc - YP;
        inb = (dx >= 0) && (dx < 16) && (dy >= 0) && (dy < 16);
        if (inb) begin
            m_code = (dx >= 8) ? m_lsd : m_msd;
            m_line = 4'(dy);
        end
        row   = rom_fn(m_code, m_line);
        e.hc  = hcount_in;
        e.vc  = vcount_in;
        e.tim = {hsync_in, vsync_in, hblnk_in, vblnk_in};
        e.rgb = (inb && row[7 - (dx % 8)]) ? TXT : rgb_in;
        sb_q.push_back(e);
        exp_code = m_code;
        exp_line = m_line;
        if (vb && !m_prev) begin
            m_msd = g_msd;
            m_lsd = g_lsd;
        end
        m_prev = vb;
    endtask

    // Release reset at a negedge with zero inputs and restart the model
    task automatic release_reset();
        exp_t z;
        @(negedge clk);
        rst = 1'b1;
        {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in} = '0;
        z = '{hc: '0, vc: '0, tim: '0, rgb: '0};
        sb_q.delete();
        repeat (3) sb_q.push_back(z);
        {m_msd, m_lsd, m_code, m_line, m_prev} = '0;
        exp_code = '0;
        exp_line = '0;
    endtask

    task automatic new_frame(input logic [6:0] msd, input logic [6:0] lsd);
        g_msd = msd;
        g_lsd = lsd;
        drive(0, 0, 1'b0);
        drive(0, 0, 1'b1);
        drive(0, 0, 1'b0);
    endtask

    task automatic drain();
        repeat (3) drive(0, 0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            hcount_in = 11'($urandom); vcount_in = 11'($urandom);
            {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'($urandom);
            rgb_in = 12'($urandom);
            msd_ascii = 7'($urandom); lsd_ascii = 7'($urandom);
            chk_cnt++;
            if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
                 char_code, char_line} !== '0)
                $display("FAIL reset_outputs got %h/%h/%h code %h line %h exp all zero",
                         hcount_out, vcount_out, rgb_out, char_code, char_line);
            else pass_cnt++;
        end
        release_reset();
        for (int i = 0; i < 6; i++) drive(int'($urandom_range(0, 1500)), int'($urandom_range(0, 900)), 1'b0);
        drain();
    endtask

    task automatic test_box_pixel();
        rom_force_en = 1'b1;
        rom_force    = 8'h80;
        new_frame(7'h31, 7'h32);
        drive(700, 20, 1'b0);
        drive(0, 0, 1'b0);
        chk_cnt++;
        if (char_code !== 7'h31 || char_line !== 4'd0)
            $display("FAIL box_addr got %h/%0d exp 31/0", char_code, char_line);
        else pass_cnt++;
        drive(0, 0, 1'b0);
        drive(0, 0, 1'b0);
        chk_cnt++;
        if (rgb_out !== TXT) $display("FAIL box_rgb got %h exp %h", rgb_out, TXT);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_lsd_half();
        logic [11:0] r708;
        rom_force_en = 1'b1;
        rom_force    = 8'h7F;
        drive(708, 25, 1'b0);
        r708 = rgb_in;
        drive(709, 25, 1'b0);
        chk_cnt++;
        if (char_code !== 7'h32 || char_line !== 4'd5)
            $display("FAIL lsd_addr got %h/%0d exp 32/5", char_code, char_line);
        else pass_cnt++;
        drive(0, 0, 1'b0);
        drive(0, 0, 1'b0);
        chk_cnt++;
        if (rgb_out !== r708) $display("FAIL lsd_bit7_clear got %h exp %h", rgb_out, r708);
        else pass_cnt++;
        drive(0, 0, 1'b0);
        chk_cnt++;
        if (rgb_out !== TXT) $display("FAIL lsd_bit6_set got %h exp %h", rgb_out, TXT);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_edges();
        rom_force_en = 1'b1;
        rom_force    = 8'hFF;
        drive(699, 25, 1'b0);
        drive(716, 25, 1'b0);
        drive(715, 25, 1'b0);
        drive(705, 19, 1'b0);
        drive(705, 36, 1'b0);
        drive(705, 35, 1'b0);
        drive(700, 20, 1'b0);
        drain();
        rom_force_en = 1'b0;
        for (int v = 18; v < 38; v++)
            for (int h = 698; h < 718; h++) drive(h, v, 1'b0);
        drain();
    endtask

    task automatic test_tear_free();
        rom_force_en = 1'b0;
        new_frame(7'h31, 7'h33);
        drive(708, 20, 1'b0);
        g_lsd = 7'h34;
        drive(0, 0, 1'b0);
        chk_cnt++;
        if (char_code !== 7'h33) $display("FAIL tear_before got %h exp 33", char_code);
        else pass_cnt++;
        drive(710, 22, 1'b0);
        drive(0, 0, 1'b0);
        chk_cnt++;
        if (char_code !== 7'h33) $display("FAIL tear_midframe got %h exp 33", char_code);
        else pass_cnt++;
        new_frame(7'h31, 7'h34);
        drive(708, 20, 1'b0);
        drive(0, 0, 1'b0);
        chk_cnt++;
        if (char_code !== 7'h34) $display("FAIL tear_after got %h exp 34", char_code);
        else pass_cnt++;
        drive(0, 0, 1'b0);
        g_lsd = 7'h35;
        drive(0, 0, 1'b1);
        g_lsd = 7'h34;
        drive(0, 0, 1'b0);
        drive(712, 30, 1'b0);
        drive(0, 0, 1'b0);
        chk_cnt++;
        if (char_code !== 7'h35) $display("FAIL same_cycle_latch got %h exp 35", char_code);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_midframe_reset();
        rom_force_en = 1'b0;
        for (int h = 700; h < 706; h++) drive(h, 24, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_cnt++;
        if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out,
             char_code, char_line} !== '0)
            $display("FAIL midframe_reset got %h/%h/%h code %h exp all zero",
                     hcount_out, vcount_out, rgb_out, char_code);
        else pass_cnt++;
        release_reset();
        new_frame(7'h39, 7'h38);
        for (int h = 700; h < 716; h++) drive(h, 27, 1'b0);
        drain();
    endtask

    initial begin
        rst = 1'b0;
        {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in} = '0;
        msd_ascii = '0; lsd_ascii = '0;
        g_msd = '0; g_lsd = '0;
        rom_force_en = 1'b0;
        rom_force = '0;
        {m_msd, m_lsd, m_code, m_line, m_prev} = '0;
        exp_code = '0;
        exp_line = '0;
        test_reset();
        test_box_pixel();
        test_lsd_half();
        test_edges();
        test_tear_free();
        test_midframe_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
